key_debouncer: RTL and testbench



---
 rtl/key_debouncer.sv | 92 +++++++++
 tb/tb_key_debouncer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - two-key synchronizer, debounce filter and press/release/long-press pulse generator
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int LONG_PRESS_CYCLES = 50000000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [1:0] KEY,
   output logic [1:0] key_level,
   output logic [1:0] key_press,
   output logic [1:0] key_release,
   output logic [1:0] key_long
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
   localparam logic [DW-1:0] DB_ONE  = DW'(1);
   localparam logic [LW-1:0] LP_ONE  = LW'(1);

   // Keys are active-low; invert on entry so everything downstream reads 1 = pressed.
   logic [1:0] sync_meta;
   logic [1:0] sync;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync_meta <= 2'b00;
         sync      <= 2'b00;
      end else begin
         sync_meta <= ~KEY;
         sync      <= sync_meta;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_key
      logic [DW-1:0] db_cnt;
      logic [LW-1:0] lp_cnt;
      logic          fired;
      logic          level;
      logic          press;
      logic          release_p;
      logic          long_p;
      logic          accept;

      assign accept = (sync[i] != level) && (db_cnt == DB_LAST);

      always_ff @(posedge Clock) begin
         if (Reset) begin
            db_cnt    <= '0;
            lp_cnt    <= '0;
            fired     <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            release_p <= 1'b0;
            long_p    <= 1'b0;
         end else begin
            press     <= accept && !level;
            release_p <= accept && level;
            long_p    <= 1'b0;

            if (sync[i] == level) begin
               db_cnt <= '0;
            end else if (accept) begin
               db_cnt <= '0;
               level  <= ~level;
            end else begin
               db_cnt <= db_cnt + DB_ONE;
            end

            // An accepted release wins over a threshold hit on the same edge.
            if (accept) begin
               lp_cnt <= '0;
               fired  <= 1'b0;
            end else if (level && !fired) begin
               if (lp_cnt == LP_LAST) begin
                  long_p <= 1'b1;
                  fired  <= 1'b1;
               end else begin
                  lp_cnt <= lp_cnt + LP_ONE;
               end
            end
         end
      end

      assign key_level[i]   = level;
      assign key_press[i]   = press;
      assign key_release[i] = release_p;
      assign key_long[i]    = long_p;
   end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - randomized scoreboard bench for key_debouncer against an event-level reference model
module tb_key_debouncer;

   localparam int D = 4;
   localparam int L = 10;
   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_LONG  = 2;

   typedef struct {
      int at;
      int key;
      int kind;
   } ev_t;

   typedef struct {
      int         at;
      logic [1:0] lvl;
   } lv_t;

   logic       Clock = 1'b1;
   logic       Reset = 1'b1;
   logic [1:0] KEY   = 2'b11;
   logic [1:0] key_level;
   logic [1:0] key_press;
   logic [1:0] key_release;
   logic [1:0] key_long;

   int checks = 0;
   int errors = 0;

   ev_t ev_q[$];
   lv_t lv_q[$];

   // Reference model state: accepted level, run of disagreeing samples, press edge.
   logic [1:0] m_level = 2'b00;
   int         m_run[2] = '{0, 0};
   int         m_press_at[2] = '{0, 0};
   bit         m_armed[2] = '{0, 0};
   logic [1:0] m_d1 = 2'b00;
   logic [1:0] m_d2 = 2'b00;
   int         edge_n = 0;

   key_debouncer #(
      .DEBOUNCE_CYCLES(D),
      .LONG_PRESS_CYCLES(L)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .KEY(KEY),
      .key_level(key_level),
      .key_press(key_press),
      .key_release(key_release),
      .key_long(key_long)
   );

   always #5 Clock = ~Clock;

   task automatic push_ev(input int at, input int key, input int kind);
      ev_t e;
      e.at = at;
      e.key = key;
      e.kind = kind;
      ev_q.push_back(e);
   endtask

   // Predicts what the DUT shows after edge n given the inputs presented at that edge.
   task automatic model_edge(input int n, input logic rst, input logic [1:0] raw);
      lv_t     l;
      logic [1:0] seen;
      seen = m_d2;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_level[i] = 1'b0;
            m_run[i]   = 0;
            m_armed[i] = 0;
         end else begin
            m_run[i] = (seen[i] != m_level[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == D) begin
               m_run[i] = 0;
               if (!m_level[i]) begin
                  push_ev(n, i, K_PRESS);
                  m_press_at[i] = n;
                  m_armed[i] = 1;
               end else begin
                  push_ev(n, i, K_REL);
                  m_armed[i] = 0;
               end
               m_level[i] = ~m_level[i];
            end else if (m_level[i] && m_armed[i] && (n - m_press_at[i] == L)) begin
               push_ev(n, i, K_LONG);
               m_armed[i] = 0;
            end
         end
      end
      if (rst) begin
         m_d1 = 2'b00;
         m_d2 = 2'b00;
      end else begin
         m_d2 = m_d1;
         m_d1 = ~raw;
      end
      l.at = n;
      l.lvl = m_level;
      lv_q.push_back(l);
   endtask

   task automatic drive(input logic rst, input logic [1:0] k, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge Clock);
         Reset = rst;
         KEY = k;
         edge_n++;
         model_edge(edge_n, rst, k);
      end
   endtask

   // Monitor: checks each edge's registered outputs against the queued predictions.
   initial begin
      int   m;
      logic pulse;
      lv_t  lv;
      ev_t  e;
      m = 0;
      forever begin
         @(posedge Clock);
         m++;
         #1;
         checks++;
         if (lv_q.size() == 0) begin
            errors++;
            $display("FAIL level_queue edge %0d: got empty queue, want an entry", m);
         end else begin
            lv = lv_q.pop_front();
            if (lv.at != m || key_level !== lv.lvl) begin
               errors++;
               $display("FAIL key_level edge %0d: got %b want %b (tag %0d)", m, key_level, lv.lvl, lv.at);
            end
         end
         for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
               pulse = (k == K_PRESS) ? key_press[i] : (k == K_REL) ? key_release[i] : key_long[i];
               if (pulse === 1'b1) begin
                  checks++;
                  if (ev_q.size() != 0 && ev_q[0].at == m) begin
                     e = ev_q.pop_front();
                     if (e.key != i || e.kind != k) begin
                        errors++;
                        $display("FAIL pulse edge %0d: got key %0d kind %0d want key %0d kind %0d", m, i, k, e.key, e.kind);
                     end
                  end else begin
                     errors++;
                     $display("FAIL unexpected_pulse edge %0d: got key %0d kind %0d want none", m, i, k);
                  end
               end
            end
         end
         while (ev_q.size() != 0 && ev_q[0].at <= m) begin
            e = ev_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse edge %0d: got none want key %0d kind %0d", e.at, e.key, e.kind);
         end
      end
   end

   initial begin
      logic [1:0] rk;
      // Reset with both keys held, then held long enough for key_long, then released.
      drive(1'b1, 2'b00, 3);
      drive(1'b0, 2'b00, 20);
      drive(1'b0, 2'b11, 12);
      // Clean press/release of key 0.
      drive(1'b0, 2'b10, 20);
      drive(1'b0, 2'b11, 12);
      // Bounce on key 1, then a steady press.
      drive(1'b0, 2'b01, 3);
      drive(1'b0, 2'b11, 1);
      drive(1'b0, 2'b01, 2);
      drive(1'b0, 2'b11, 4);
      drive(1'b0, 2'b01, 10);
      drive(1'b0, 2'b11, 12);
      // Short press: released before the long-press threshold.
      drive(1'b0, 2'b10, 8);
      drive(1'b0, 2'b11, 12);
      // Simultaneous press, key 1 released early.
      drive(1'b0, 2'b00, 8);
      drive(1'b0, 2'b10, 15);
      drive(1'b0, 2'b11, 12);
      // Reset pulse mid long-press, key stays held.
      drive(1'b0, 2'b10, 11);
      drive(1'b1, 2'b10, 1);
      drive(1'b0, 2'b10, 25);
      drive(1'b0, 2'b11, 12);
      // Random key activity with occasional resets.
      for (int s = 0; s < 300; s++) begin
         rk = 2'($urandom_range(0, 3));
         drive(($urandom_range(0, 39) == 0), rk, $urandom_range(1, 14));
      end
      drive(1'b0, 2'b11, 30);
      @(posedge Clock);
      #2;
      checks++;
      if (ev_q.size() != 0 || lv_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d events %0d levels pending, want 0 0", ev_q.size(), lv_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
